// File: rtl/lsu_sequencer.sv
// Load/store sequencer between core control and the data memory port.
// Issues word-aligned beats, splits word-crossing accesses, merges and extends load data.
module lsu_sequencer #(
  parameter int unsigned ADDR_W         = 32,
  parameter bit          MISALIGN_SPLIT = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  input  logic              mem_ready,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [3:0]        mem_req_rmask,
  output logic [3:0]        mem_req_wmask,
  output logic [31:0]       mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_data
);

  typedef enum logic [2:0] {StIdle, StIssue0, StWait0, StIssue1, StWait1, StDone} state_e;

  state_e            state_q, state_d;
  logic              store_q, store_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       beat0_q, beat0_d;
  logic [31:0]       beat1_q, beat1_d;
  logic              err_q, err_d;
  logic [31:0]       cnt_q, cnt_d;

  logic [1:0]        offset;
  logic [2:0]        size_bytes;
  logic [3:0]        base_mask;
  logic              crossing, illegal, reject;
  logic [ADDR_W-1:0] beat0_addr, beat1_addr;
  logic [3:0]        mask0, mask1;
  logic [31:0]       wdata0, wdata1;
  logic [31:0]       load_word, load_result;
  logic [31:0]       cnt_inc;
  logic              timeout_hit;

  // Access decode, all from the latched request.
  always_comb begin
    offset = addr_q[1:0];
    unique case (funct3_q[1:0])
      2'b00:   begin size_bytes = 3'd1; base_mask = 4'b0001; end
      2'b01:   begin size_bytes = 3'd2; base_mask = 4'b0011; end
      default: begin size_bytes = 3'd4; base_mask = 4'b1111; end
    endcase
    crossing   = ({1'b0, offset} + size_bytes) > 3'd4;
    illegal    = store_q ? (funct3_q >= 3'b011)
                         : ((funct3_q == 3'b011) || (funct3_q[2:1] == 2'b11));
    reject     = illegal || (crossing && !MISALIGN_SPLIT);
    beat0_addr = {addr_q[ADDR_W-1:2], 2'b00};
    beat1_addr = beat0_addr + ADDR_W'(4);
    mask0      = 4'({4'b0000, base_mask} << offset);
    mask1      = base_mask >> (3'd4 - {1'b0, offset});
    wdata0     = wdata_q << {offset, 3'b000};
    wdata1     = wdata_q >> {(3'd4 - {1'b0, offset}), 3'b000};
    load_word  = 32'({beat1_q, beat0_q} >> {offset, 3'b000});
    unique case (funct3_q)
      3'b000:  load_result = {{24{load_word[7]}}, load_word[7:0]};
      3'b001:  load_result = {{16{load_word[15]}}, load_word[15:0]};
      3'b100:  load_result = {24'h0, load_word[7:0]};
      3'b101:  load_result = {16'h0, load_word[15:0]};
      default: load_result = load_word;
    endcase
    cnt_inc     = cnt_q + 32'd1;
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == 32'(TIMEOUT_CYCLES));
  end

  always_comb begin
    state_d       = state_q;
    store_d       = store_q;
    funct3_d      = funct3_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    beat0_d       = beat0_q;
    beat1_d       = beat1_q;
    err_d         = err_q;
    cnt_d         = cnt_q;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    mem_req_rmask = 4'b0000;
    mem_req_wmask = 4'b0000;
    mem_req_wdata = 32'h0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          store_d  = req_store;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          beat0_d  = 32'h0;
          beat1_d  = 32'h0;
          err_d    = 1'b0;
          state_d  = StIssue0;
        end
      end
      StIssue0: begin
        // Rejected requests finish from here without ever driving a beat.
        if (reject) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else if (mem_ready) begin
          mem_req_valid = 1'b1;
          mem_req_addr  = beat0_addr;
          mem_req_rmask = store_q ? 4'b0000 : mask0;
          mem_req_wmask = store_q ? mask0 : 4'b0000;
          mem_req_wdata = wdata0;
          cnt_d         = 32'h0;
          state_d       = StWait0;
        end
      end
      StWait0: begin
        if (mem_rsp_valid) begin
          beat0_d = mem_rsp_data;
          state_d = crossing ? StIssue1 : StDone;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StIssue1: begin
        if (mem_ready) begin
          mem_req_valid = 1'b1;
          mem_req_addr  = beat1_addr;
          mem_req_rmask = store_q ? 4'b0000 : mask1;
          mem_req_wmask = store_q ? mask1 : 4'b0000;
          mem_req_wdata = wdata1;
          cnt_d         = 32'h0;
          state_d       = StWait1;
        end
      end
      StWait1: begin
        if (mem_rsp_valid) begin
          beat1_d = mem_rsp_data;
          state_d = StDone;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StDone: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StDone);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && !err_q && !store_q) ? load_result : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      store_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      beat0_q  <= 32'h0;
      beat1_q  <= 32'h0;
      err_q    <= 1'b0;
      cnt_q    <= 32'h0;
    end else begin
      state_q  <= state_d;
      store_q  <= store_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      beat0_q  <= beat0_d;
      beat1_q  <= beat1_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
